// File: rtl/div_unit_pkg.sv
// Shared constants for the multi-cycle divider: data width, counter width
// and the 2-bit FSM state encodings.
package div_unit_pkg;

  localparam int REG_DATA_WIDTH = 32;
  localparam int DIV_CNT_W      = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_ZERO = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_abs_sign.sv
// Conditional two's-complement negation: yields operand magnitudes on the way
// in and applies quotient/remainder sign correction on the way out.
module div_abs_sign #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN finishes at once when |dividend| < |divisor|.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = REG_DATA_WIDTH,
  parameter int CNT_W  = DIV_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic              signed_in,
  input  logic [DATA_W-1:0] dividend_in,
  input  logic [DATA_W-1:0] divisor_in,
  input  logic              annul_in,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              ready_out,
  output logic              stall_req_out
);

  div_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] acc_q, quo_q, dvs_q, hi_q, lo_q;
  logic              neg_quo_q, neg_rem_q, ready_q;

  logic              dvd_neg, dvs_neg;
  logic [DATA_W-1:0] dvd_mag, dvs_mag;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W-1:0] diff, acc_d, quo_d, hi_fix, lo_fix;
  logic              borrow;

  assign dvd_neg = signed_in & dividend_in[DATA_W-1];
  assign dvs_neg = signed_in & divisor_in[DATA_W-1];

  div_abs_sign #(.W(DATA_W)) u_dvd_abs (.val_i(dividend_in), .neg_i(dvd_neg),   .res_o(dvd_mag));
  div_abs_sign #(.W(DATA_W)) u_dvs_abs (.val_i(divisor_in),  .neg_i(dvs_neg),   .res_o(dvs_mag));
  div_abs_sign #(.W(DATA_W)) u_quo_fix (.val_i(quo_d),       .neg_i(neg_quo_q), .res_o(lo_fix));
  div_abs_sign #(.W(DATA_W)) u_rem_fix (.val_i(acc_d),       .neg_i(neg_rem_q), .res_o(hi_fix));

  // The shifted partial remainder needs one extra bit; when the subtraction
  // succeeds the true difference is below the divisor, so the low bits suffice.
  assign rem_sh = {acc_q, quo_q[DATA_W-1]};
  assign borrow = rem_sh < {1'b0, dvs_q};
  assign diff   = rem_sh[DATA_W-1:0] - dvs_q;
  assign acc_d  = borrow ? rem_sh[DATA_W-1:0] : diff;
  assign quo_d  = {quo_q[DATA_W-2:0], ~borrow};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          ready_q <= 1'b0;
          hi_q    <= '0;
          lo_q    <= '0;
          if (start_in && !annul_in) begin
            dvs_q     <= dvs_mag;
            quo_q     <= dvd_mag;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= dvd_neg ^ dvs_neg;
            neg_rem_q <= dvd_neg;
            if (divisor_in == '0) begin
              state_q <= DIV_ZERO;
`ifdef DIV_EARLY_OUT_EN
            end else if (dvd_mag < dvs_mag) begin
              state_q <= DIV_DONE;
              hi_q    <= dividend_in;
              lo_q    <= '0;
`endif
            end else begin
              state_q <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          if (annul_in) begin
            state_q <= DIV_IDLE;
          end else begin
            acc_q <= acc_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              state_q <= DIV_DONE;
              hi_q    <= hi_fix;
              lo_q    <= lo_fix;
            end
          end
        end
        DIV_ZERO: begin
          if (annul_in) begin
            state_q <= DIV_IDLE;
          end else begin
            state_q <= DIV_DONE;
            hi_q    <= '0;
            lo_q    <= '0;
          end
        end
        DIV_DONE: begin
          if (start_in) begin
            ready_q <= 1'b1;
          end else begin
            state_q <= DIV_IDLE;
            ready_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
          end
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  assign hi_out        = hi_q;
  assign lo_out        = lo_q;
  assign ready_out     = ready_q;
  assign stall_req_out = start_in & ~ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit; build with DIV_EARLY_OUT_EN
// defined to exercise the early-out latency.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, start_in, signed_in, annul_in;
  logic [31:0] dividend_in, divisor_in, hi_out, lo_out;
  logic        ready_out, stall_req_out;

  int checks = 0;
  int errors = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int SMALL_LAT = 1;
`else
  localparam int SMALL_LAT = 33;
`endif

  always #5 clk = ~clk;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .start_in     (start_in),
    .signed_in    (signed_in),
    .dividend_in  (dividend_in),
    .divisor_in   (divisor_in),
    .annul_in     (annul_in),
    .hi_out       (hi_out),
    .lo_out       (lo_out),
    .ready_out    (ready_out),
    .stall_req_out(stall_req_out)
  );

  // Raise start with the given operands and wait (bounded) for ready_out.
  // lat = edges after the accepting edge; -1 on timeout. start stays high.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int stalls);
    @(negedge clk);
    signed_in   = s;
    dividend_in = a;
    divisor_in  = b;
    start_in    = 1'b1;
    lat    = -1;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready_out) begin
        lat = i;
        break;
      end
      if (stall_req_out) stalls++;
    end
    $display("op s=%0d %h / %h -> hi=%h lo=%h lat=%0d", s, a, b, hi_out, lo_out, lat);
  endtask

  task automatic drop_start();
    start_in = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start_in = 1'b0; signed_in = 1'b0; annul_in = 1'b0;
    dividend_in = '0; divisor_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready_out); end
    checks++; if (hi_out !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi_out); end
    checks++; if (lo_out !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo_out); end
    checks++; if (stall_req_out !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall_req_out); end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat, st;
    run_op(1'b0, 32'd100, 32'd7, lat, st);
    checks++; if (lat !== 33) begin errors++; $display("FAIL udiv_lat got %0d exp 33", lat); end
    checks++; if (st !== 33) begin errors++; $display("FAIL udiv_stall_cycles got %0d exp 33", st); end
    checks++; if (lo_out !== 32'd14) begin errors++; $display("FAIL udiv_lo got %h exp %h", lo_out, 32'd14); end
    checks++; if (hi_out !== 32'd2) begin errors++; $display("FAIL udiv_hi got %h exp %h", hi_out, 32'd2); end
    checks++; if (stall_req_out !== 1'b0) begin errors++; $display("FAIL udiv_stall_at_ready got %b exp 0", stall_req_out); end
    drop_start();
  endtask

  task automatic test_signed();
    int lat, st;
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, st);
    checks++; if (lo_out !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sdiv_m7_2_lo got %h exp FFFFFFFD", lo_out); end
    checks++; if (hi_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdiv_m7_2_hi got %h exp FFFFFFFF", hi_out); end
    drop_start();
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat, st);
    checks++; if (lo_out !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sdiv_7_m2_lo got %h exp FFFFFFFD", lo_out); end
    checks++; if (hi_out !== 32'd1) begin errors++; $display("FAIL sdiv_7_m2_hi got %h exp 00000001", hi_out); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL sdiv_lat got %0d exp 33", lat); end
    drop_start();
  endtask

  task automatic test_div_zero();
    int lat, st;
    run_op(1'b0, 32'd5, 32'd0, lat, st);
    checks++; if (lat !== 2) begin errors++; $display("FAIL div0_lat got %0d exp 2", lat); end
    checks++; if (hi_out !== 32'h0) begin errors++; $display("FAIL div0_hi got %h exp 0", hi_out); end
    checks++; if (lo_out !== 32'h0) begin errors++; $display("FAIL div0_lo got %h exp 0", lo_out); end
    drop_start();
  endtask

  task automatic test_overflow();
    int lat, st;
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, st);
    checks++; if (lo_out !== 32'h8000_0000) begin errors++; $display("FAIL ovf_lo got %h exp 80000000", lo_out); end
    checks++; if (hi_out !== 32'h0) begin errors++; $display("FAIL ovf_hi got %h exp 0", hi_out); end
    drop_start();
  endtask

  task automatic test_annul();
    int lat, st;
    @(negedge clk);
    signed_in = 1'b0; dividend_in = 32'd100; divisor_in = 32'd7; start_in = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    annul_in = 1'b0;
    start_in = 1'b0;
    st = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready_out) st++;
    end
    $display("op annul after iteration 10, ready pulses=%0d", st);
    checks++; if (st !== 0) begin errors++; $display("FAIL annul_ready got %0d pulses exp 0", st); end
    run_op(1'b0, 32'd12, 32'd4, lat, st);
    checks++; if (lat !== 33) begin errors++; $display("FAIL post_annul_lat got %0d exp 33", lat); end
    checks++; if (lo_out !== 32'd3) begin errors++; $display("FAIL post_annul_lo got %h exp 3", lo_out); end
    checks++; if (hi_out !== 32'd0) begin errors++; $display("FAIL post_annul_hi got %h exp 0", hi_out); end
    drop_start();
  endtask

  task automatic test_hold_done();
    int lat, st;
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, lat, st);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL hold_ready[%0d] got %b exp 1", i, ready_out); end
      checks++; if (lo_out !== 32'hFFFF_FFF2) begin errors++; $display("FAIL hold_lo[%0d] got %h exp FFFFFFF2", i, lo_out); end
      checks++; if (hi_out !== 32'hFFFF_FFFE) begin errors++; $display("FAIL hold_hi[%0d] got %h exp FFFFFFFE", i, hi_out); end
    end
    start_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL drop_ready got %b exp 0", ready_out); end
    checks++; if (hi_out !== 32'h0) begin errors++; $display("FAIL drop_hi got %h exp 0", hi_out); end
    checks++; if (lo_out !== 32'h0) begin errors++; $display("FAIL drop_lo got %h exp 0", lo_out); end
  endtask

  task automatic test_reset_midop();
    int lat, st;
    @(negedge clk);
    signed_in = 1'b0; dividend_in = 32'd100; divisor_in = 32'd7; start_in = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    start_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    $display("op reset at iteration 20 -> hi=%h lo=%h ready=%b", hi_out, lo_out, ready_out);
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL rst_mid_ready got %b exp 0", ready_out); end
    checks++; if (hi_out !== 32'h0) begin errors++; $display("FAIL rst_mid_hi got %h exp 0", hi_out); end
    checks++; if (lo_out !== 32'h0) begin errors++; $display("FAIL rst_mid_lo got %h exp 0", lo_out); end
    checks++; if (stall_req_out !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got %b exp 0", stall_req_out); end
    rst = 1'b0;
    run_op(1'b0, 32'd12, 32'd4, lat, st);
    checks++; if (lat !== 33) begin errors++; $display("FAIL post_rst_lat got %0d exp 33", lat); end
    checks++; if (lo_out !== 32'd3) begin errors++; $display("FAIL post_rst_lo got %h exp 3", lo_out); end
    drop_start();
  endtask

  task automatic test_small();
    int lat, st;
    run_op(1'b0, 32'd3, 32'd10, lat, st);
    checks++; if (lat !== SMALL_LAT) begin errors++; $display("FAIL small_lat got %0d exp %0d", lat, SMALL_LAT); end
    checks++; if (lo_out !== 32'd0) begin errors++; $display("FAIL small_lo got %h exp 0", lo_out); end
    checks++; if (hi_out !== 32'd3) begin errors++; $display("FAIL small_hi got %h exp 3", hi_out); end
    drop_start();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_annul();
    test_hold_done();
    test_reset_midop();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
